tft_line_buffer_pp: RTL and testbench

Parametrised dual-clock, ping-pong line buffer between the system-clock pixel fetch path and the TFT timing generator. It holds two full scanlines in separate banks. The fetch side writes one bank while the TFT side displays the other. Banks are exchanged at Rd_start_line with credit-based flow control across the clock boundary. It adds optional integer horizontal pixel replication and reports underflow.

---
 rtl/tft_line_buffer_pp.sv | 259 +++++++++++++++++++++++++
 tb/tb_tft_line_buffer_pp.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_line_buffer_pp.sv
// tft_line_buffer_pp: dual-clock ping-pong line buffer between the system-clock
// pixel fetch path and the TFT timing generator.
//
// The fetch side (sys_clk) fills one of two line banks while the TFT side
// (TFT_Clk) displays the other. Completed lines are handed across the clock
// boundary with a toggle, and displayed banks are handed back the same way.
// This gives credit-based flow control with at most two lines in flight.
//
// Ports
//   TFT_Clk, TFT_Rst     display clock, async active-high reset
//   sys_clk, sys_rst     fetch clock, async active-high reset
//   Rd_start_line        TFT: 1-cycle pulse before each active line
//   BRAM_TFT_rd          TFT: high for the active-line read window
//   BRAM_TFT_oe          TFT: output enable, RGB forced to 0 when low
//   PLB_BRAM_data        sys: PIX_PER_WORD x 32-bit slots, slot k = {xx, R, G, B}
//   PLB_BRAM_we          sys: write strobe, one word per cycle
//   PLB_BRAM_ready       sys: current write bank is free
//   line_ready           TFT: at least one completed line is queued
//   underflow            TFT: 1-cycle pulse when a line start finds nothing queued
//   RED, GREEN, BLUE     TFT: registered pixel data
module tft_line_buffer_pp #(
  parameter int unsigned H_ACTIVE     = 1280,
  parameter int unsigned PIX_PER_WORD = 4,
  parameter int unsigned H_SCALE      = 1
) (
  input  logic                      TFT_Clk,
  input  logic                      TFT_Rst,
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      Rd_start_line,
  input  logic                      BRAM_TFT_rd,
  input  logic                      BRAM_TFT_oe,
  input  logic [32*PIX_PER_WORD-1:0] PLB_BRAM_data,
  input  logic                      PLB_BRAM_we,
  output logic                      PLB_BRAM_ready,
  output logic                      line_ready,
  output logic                      underflow,
  output logic [7:0]                RED,
  output logic [7:0]                GREEN,
  output logic [7:0]                BLUE
);

  localparam int unsigned WORDS_PER_LINE = H_ACTIVE / PIX_PER_WORD;
  localparam int unsigned DEPTH          = 2 * H_ACTIVE;
  localparam int unsigned ADDR_W         = $clog2(DEPTH);
  localparam int unsigned PIX_W          = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned WPTR_W         = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  // Line storage: bank b occupies addresses [b*H_ACTIVE, (b+1)*H_ACTIVE).
  logic [23:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Fetch (sys_clk) domain
  // ---------------------------------------------------------------------------
  logic [WPTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rel_bank_q, rel_bank_d;
  logic [1:0]        bank_free_q, bank_free_d;
  logic              wr_done_tgl_q, wr_done_tgl_d;
  logic [1:0]        rel_sync_q;
  logic              rel_seen_q;
  logic              rel_tgl_q, rel_tgl_d;

  logic              wr_accept;
  logic              wr_last;
  logic              rel_edge;
  logic [ADDR_W-1:0] wr_base;
  logic [8*PIX_PER_WORD-1:0] unused_hi;

  assign PLB_BRAM_ready = bank_free_q[wr_bank_q];
  assign wr_accept      = PLB_BRAM_we && bank_free_q[wr_bank_q];
  assign wr_last        = (wr_ptr_q == WPTR_W'(WORDS_PER_LINE - 1));
  assign rel_edge       = rel_sync_q[1] ^ rel_seen_q;
  assign wr_base        = (wr_bank_q ? ADDR_W'(H_ACTIVE) : ADDR_W'(0))
                        + ADDR_W'(wr_ptr_q) * ADDR_W'(PIX_PER_WORD);

  // Top byte of each 32-bit slot carries no pixel data.
  always_comb begin
    unused_hi = '0;
    for (int k = 0; k < int'(PIX_PER_WORD); k++) begin
      unused_hi[8*k +: 8] = PLB_BRAM_data[32*k+24 +: 8];
    end
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    wr_bank_d     = wr_bank_q;
    rel_bank_d    = rel_bank_q;
    bank_free_d   = bank_free_q;
    wr_done_tgl_d = wr_done_tgl_q;
    if (wr_accept) begin
      if (wr_last) begin
        wr_ptr_d               = '0;
        bank_free_d[wr_bank_q] = 1'b0;
        wr_bank_d              = ~wr_bank_q;
        wr_done_tgl_d          = ~wr_done_tgl_q;
      end else begin
        wr_ptr_d = wr_ptr_q + WPTR_W'(1);
      end
    end
    // Releases arrive in display order, so a single rotating index suffices.
    // The released bank is never the bank being filled, so this cannot
    // collide with the clear above.
    if (rel_edge) begin
      bank_free_d[rel_bank_q] = 1'b1;
      rel_bank_d              = ~rel_bank_q;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q      <= '0;
      wr_bank_q     <= 1'b0;
      rel_bank_q    <= 1'b0;
      bank_free_q   <= 2'b11;
      wr_done_tgl_q <= 1'b0;
      rel_sync_q    <= 2'b00;
      rel_seen_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      wr_bank_q     <= wr_bank_d;
      rel_bank_q    <= rel_bank_d;
      bank_free_q   <= bank_free_d;
      wr_done_tgl_q <= wr_done_tgl_d;
      rel_sync_q    <= {rel_sync_q[0], rel_tgl_q};
      rel_seen_q    <= rel_sync_q[1];
    end
  end

  // Wide write port: one word places PIX_PER_WORD consecutive pixels.
  always_ff @(posedge sys_clk) begin
    if (wr_accept) begin
      for (int k = 0; k < int'(PIX_PER_WORD); k++) begin
        mem[wr_base + ADDR_W'(k)] <= PLB_BRAM_data[32*k +: 24];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display (TFT_Clk) domain
  // ---------------------------------------------------------------------------
  logic [1:0]       done_sync_q;
  logic             done_seen_q;
  logic [1:0]       queued_q, queued_d;
  logic             held_q, held_d;
  logic             rd_bank_q, rd_bank_d;
  logic             rd_next_q, rd_next_d;
  logic             underflow_q, underflow_d;
  logic [PIX_W-1:0] rd_addr_q, rd_addr_d;
  logic             phase_q, phase_d;
  logic             tc_q, tc_d;
  logic             tc_rd_q;
  logic [23:0]      rd_data_q;
  logic [23:0]      rgb_q, rgb_d;

  logic             done_edge;
  logic             consume;
  logic             phase_last;
  logic [ADDR_W-1:0] rd_ram_addr;

  assign done_edge   = done_sync_q[1] ^ done_seen_q;
  assign consume     = Rd_start_line && (queued_q != 2'd0);
  assign phase_last  = (phase_q == 1'(H_SCALE - 1));
  assign rd_ram_addr = (rd_bank_q ? ADDR_W'(H_ACTIVE) : ADDR_W'(0)) + ADDR_W'(rd_addr_q);

  assign line_ready = (queued_q != 2'd0);
  assign underflow  = underflow_q;
  assign RED        = rgb_q[23:16];
  assign GREEN      = rgb_q[15:8];
  assign BLUE       = rgb_q[7:0];

  // Line queue and bank hand-over.
  always_comb begin
    queued_d    = queued_q;
    held_d      = held_q;
    rd_bank_d   = rd_bank_q;
    rd_next_d   = rd_next_q;
    rel_tgl_d   = rel_tgl_q;
    underflow_d = Rd_start_line && (queued_q == 2'd0);
    case ({done_edge, consume})
      2'b10:   queued_d = queued_q + 2'd1;
      2'b01:   queued_d = queued_q - 2'd1;
      default: queued_d = queued_q;
    endcase
    if (consume) begin
      rd_bank_d = rd_next_q;
      rd_next_d = ~rd_next_q;
      // The first line after reset has no previously displayed bank to return.
      if (held_q) rel_tgl_d = ~rel_tgl_q;
      held_d = 1'b1;
    end
  end

  // Read address with horizontal replication; tc parks the line once done.
  always_comb begin
    rd_addr_d = rd_addr_q;
    phase_d   = phase_q;
    tc_d      = tc_q;
    if (!BRAM_TFT_rd) begin
      rd_addr_d = '0;
      phase_d   = 1'b0;
      tc_d      = 1'b0;
    end else if (!tc_q) begin
      if (phase_last) begin
        phase_d = 1'b0;
        if (rd_addr_q == PIX_W'(H_ACTIVE - 1)) begin
          rd_addr_d = '0;
          tc_d      = 1'b1;
        end else begin
          rd_addr_d = rd_addr_q + PIX_W'(1);
        end
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_comb begin
    rgb_d = (BRAM_TFT_oe && !tc_rd_q) ? rd_data_q : 24'd0;
  end

  always_ff @(posedge TFT_Clk or posedge TFT_Rst) begin
    if (TFT_Rst) begin
      done_sync_q <= 2'b00;
      done_seen_q <= 1'b0;
      queued_q    <= 2'd0;
      held_q      <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_next_q   <= 1'b0;
      rel_tgl_q   <= 1'b0;
      underflow_q <= 1'b0;
      rd_addr_q   <= '0;
      phase_q     <= 1'b0;
      tc_q        <= 1'b0;
      tc_rd_q     <= 1'b0;
      rgb_q       <= 24'd0;
    end else begin
      done_sync_q <= {done_sync_q[0], wr_done_tgl_q};
      done_seen_q <= done_sync_q[1];
      queued_q    <= queued_d;
      held_q      <= held_d;
      rd_bank_q   <= rd_bank_d;
      rd_next_q   <= rd_next_d;
      rel_tgl_q   <= rel_tgl_d;
      underflow_q <= underflow_d;
      rd_addr_q   <= rd_addr_d;
      phase_q     <= phase_d;
      tc_q        <= tc_d;
      tc_rd_q     <= tc_q;
      rgb_q       <= rgb_d;
    end
  end

  // Synchronous RAM read; the output register adds the second cycle.
  always_ff @(posedge TFT_Clk) begin
    rd_data_q <= mem[rd_ram_addr];
  end

endmodule

// File: tb/tb_tft_line_buffer_pp.sv
module tb_tft_line_buffer_pp;

  logic TFT_Clk = 1'b0;
  logic sys_clk = 1'b0;
  logic TFT_Rst, sys_rst;
  always #5 TFT_Clk = ~TFT_Clk;
  always #4 sys_clk = ~sys_clk;

  // Default instance: 1280 pixels, 4 per word, no replication.
  logic         start, rd, oe, we;
  logic [127:0] data;
  logic         ready, lrdy, uflow;
  logic [7:0]   red, green, blue;
  logic [23:0]  rgb;
  assign rgb = {red, green, blue};

  tft_line_buffer_pp u_dut (
    .TFT_Clk        (TFT_Clk),
    .TFT_Rst        (TFT_Rst),
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .Rd_start_line  (start),
    .BRAM_TFT_rd    (rd),
    .BRAM_TFT_oe    (oe),
    .PLB_BRAM_data  (data),
    .PLB_BRAM_we    (we),
    .PLB_BRAM_ready (ready),
    .line_ready     (lrdy),
    .underflow      (uflow),
    .RED            (red),
    .GREEN          (green),
    .BLUE           (blue)
  );

  // Small instance: 8 pixels, 2 per word, replicated x2.
  logic        start2, rd2, oe2, we2;
  logic [63:0] data2;
  logic        ready2, lrdy2, uflow2;
  logic [7:0]  red2, green2, blue2;
  logic [23:0] rgb2;
  assign rgb2 = {red2, green2, blue2};

  tft_line_buffer_pp #(
    .H_ACTIVE     (8),
    .PIX_PER_WORD (2),
    .H_SCALE      (2)
  ) u_dut2 (
    .TFT_Clk        (TFT_Clk),
    .TFT_Rst        (TFT_Rst),
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .Rd_start_line  (start2),
    .BRAM_TFT_rd    (rd2),
    .BRAM_TFT_oe    (oe2),
    .PLB_BRAM_data  (data2),
    .PLB_BRAM_we    (we2),
    .PLB_BRAM_ready (ready2),
    .line_ready     (lrdy2),
    .underflow      (uflow2),
    .RED            (red2),
    .GREEN          (green2),
    .BLUE           (blue2)
  );

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pixel for line 'tag', position n: R=tag, G=n[15:8], B=n[7:0].
  function automatic logic [23:0] pix(input int tag, input int n);
    return {tag[7:0], n[15:0]};
  endfunction

  // Junk in the ignored top byte of every slot.
  function automatic logic [127:0] mk_word(input int tag, input int w);
    logic [127:0] v;
    for (int k = 0; k < 4; k++) v[32*k +: 32] = {8'hC3, pix(tag, w*4 + k)};
    return v;
  endfunction

  function automatic logic [23:0] pix2(input int n);
    logic [15:0] t;
    t = 16'(n) + 16'h0300;
    return {8'h5A, t};
  endfunction

  task automatic write_line(input int tag);
    for (int w = 0; w < 320; w++) begin
      @(negedge sys_clk);
      we   = 1'b1;
      data = mk_word(tag, w);
    end
    @(negedge sys_clk);
    we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge TFT_Clk);
    start = 1'b1;
    @(negedge TFT_Clk);
    start = 1'b0;
  endtask

  // Full line read; oe is low for displayed pixels lo..hi.
  task automatic read_line(input string tag, input int line_tag, input int lo, input int hi);
    int p;
    for (int c = 0; c <= 1281; c++) begin
      @(negedge TFT_Clk);
      if (c >= 2) begin
        p = c - 2;
        check(tag, 32'(rgb), (p >= lo && p <= hi) ? 32'd0 : 32'(pix(line_tag, p)));
      end
      if (c == 0) rd = 1'b1;
      if (c == 1280) rd = 1'b0;
      oe = !((c - 1) >= lo && (c - 1) <= hi);
    end
    @(negedge TFT_Clk);
    oe = 1'b0;
  endtask

  initial begin
    int seen_uf;
    int p;
    n_tests = 0;
    n_fail  = 0;
    start = 1'b0; rd = 1'b0; oe = 1'b0; we = 1'b0; data = '0;
    start2 = 1'b0; rd2 = 1'b0; oe2 = 1'b0; we2 = 1'b0; data2 = '0;
    TFT_Rst = 1'b1;
    sys_rst = 1'b1;

    // Reset state
    repeat (3) @(negedge TFT_Clk);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_underflow", 32'(uflow), 32'd0);
    check("rst_line_ready", 32'(lrdy), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    TFT_Rst = 1'b0;
    sys_rst = 1'b0;
    repeat (2) @(negedge TFT_Clk);

    // One line, displayed in full
    write_line(0);
    check("l0_ready_bank1_free", 32'(ready), 32'd1);
    repeat (4) @(negedge TFT_Clk);
    check("l0_line_ready", 32'(lrdy), 32'd1);
    pulse_start();
    check("l0_consumed", 32'(lrdy), 32'd0);
    check("l0_no_underflow", 32'(uflow), 32'd0);
    read_line("l0_px", 0, -1, -2);
    check("l0_ready_after_read", 32'(ready), 32'd1);

    // Underflow: previous line repeats; oe gap on pixels 100..109
    @(negedge TFT_Clk);
    start = 1'b1;
    @(negedge TFT_Clk);
    start = 1'b0;
    check("uf_pulse", 32'(uflow), 32'd1);
    @(negedge TFT_Clk);
    check("uf_one_cycle", 32'(uflow), 32'd0);
    check("uf_queue_empty", 32'(lrdy), 32'd0);
    read_line("uf_repeat_px", 0, 100, 109);

    // Two lines without reading fill both banks
    TFT_Rst = 1'b1;
    sys_rst = 1'b1;
    repeat (2) @(negedge TFT_Clk);
    TFT_Rst = 1'b0;
    sys_rst = 1'b0;
    repeat (2) @(negedge TFT_Clk);
    write_line(1);
    check("pp_ready_after_320", 32'(ready), 32'd1);
    write_line(2);
    check("pp_ready_after_640", 32'(ready), 32'd0);
    @(negedge sys_clk);
    we   = 1'b1;
    data = mk_word(8'hEE, 0);  // must be dropped
    @(negedge sys_clk);
    we = 1'b0;
    check("pp_ready_after_drop", 32'(ready), 32'd0);
    repeat (4) @(negedge TFT_Clk);
    check("pp_line_ready", 32'(lrdy), 32'd1);
    pulse_start();
    check("pp_start1_no_uf", 32'(uflow), 32'd0);
    check("pp_start1_one_left", 32'(lrdy), 32'd1);
    repeat (10) @(negedge sys_clk);
    check("pp_start1_no_release", 32'(ready), 32'd0);
    read_line("pp_l1_px", 1, -1, -2);
    pulse_start();
    check("pp_start2_empty", 32'(lrdy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (ready) break;
    end
    check("pp_ready_after_release", 32'(ready), 32'd1);
    write_line(3);
    check("pp_l3_ready", 32'(ready), 32'd0);
    repeat (4) @(negedge TFT_Clk);
    check("pp_l3_line_ready", 32'(lrdy), 32'd1);

    // Reset both sides in the middle of line 2
    for (int c = 0; c < 52; c++) begin
      @(negedge TFT_Clk);
      if (c >= 2) check("pp_l2_px", 32'(rgb), 32'(pix(2, c - 2)));
      if (c == 0) begin
        rd = 1'b1;
        oe = 1'b1;
      end
    end
    #2;
    TFT_Rst = 1'b1;
    sys_rst = 1'b1;
    #1;
    check("mrst_rgb", 32'(rgb), 32'd0);
    check("mrst_ready", 32'(ready), 32'd1);
    check("mrst_line_ready", 32'(lrdy), 32'd0);
    check("mrst_underflow", 32'(uflow), 32'd0);
    rd = 1'b0;
    oe = 1'b0;
    repeat (3) @(negedge TFT_Clk);
    TFT_Rst = 1'b0;
    sys_rst = 1'b0;
    seen_uf = 0;
    repeat (10) begin
      @(negedge TFT_Clk);
      if (uflow) seen_uf++;
    end
    check("mrst_no_spurious_uf", 32'(seen_uf), 32'd0);

    // Replication x2 on the small instance
    for (int w = 0; w < 4; w++) begin
      @(negedge sys_clk);
      we2   = 1'b1;
      data2 = {8'hA5, pix2(2*w + 1), 8'hA5, pix2(2*w)};
    end
    @(negedge sys_clk);
    we2 = 1'b0;
    repeat (4) @(negedge TFT_Clk);
    check("hs2_line_ready", 32'(lrdy2), 32'd1);
    @(negedge TFT_Clk);
    start2 = 1'b1;
    @(negedge TFT_Clk);
    start2 = 1'b0;
    for (int c = 0; c < 22; c++) begin
      @(negedge TFT_Clk);
      if (c >= 2) begin
        p = c - 2;
        check("hs2_px", 32'(rgb2), (p < 16) ? 32'(pix2(p / 2)) : 32'd0);
      end
      if (c == 0) begin
        rd2 = 1'b1;
        oe2 = 1'b1;
      end
    end
    rd2 = 1'b0;
    oe2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
